s_store_ctrl: RTL and testbench



---
 rtl/s_store_ctrl.sv | 136 +++++++++++++
 tb/tb_s_store_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/s_store_ctrl.sv
// S-type store sequencer: decodes SB/SH/SW, reads rs1/rs2 from a synchronous-read
// register file, forms address/strobes/lane data and issues one data-memory write.
module s_store_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_valid,
   output logic        inst_ready,
   input  logic [31:0] instruction_word,
   output logic [4:0]  rf_rs1_addr,
   output logic [4:0]  rf_rs2_addr,
   input  logic [31:0] rf_rs1_data,
   input  logic [31:0] rf_rs2_data,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   output logic        busy,
   output logic        done,
   output logic        fault,
   output logic [1:0]  fault_cause,
   output logic [31:0] fault_addr
);

   // state   | meaning
   // IDLE    | ready for a new instruction
   // READ    | register-file addresses presented, data arrives next cycle
   // EXEC    | compute ea, lanes, legality and alignment
   // MEM     | write request outstanding until mem_ready
   // DONE    | one-cycle completion pulse
   // FAULT   | one-cycle abort pulse, no memory request
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_EXEC  = 3'd2,
      S_MEM   = 3'd3,
      S_DONE  = 3'd4,
      S_FAULT = 3'd5
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] inst_q;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [31:0] imm;
   logic [31:0] ea;
   logic        illegal;
   logic        misaligned;
   logic [3:0]  wstrb_c;
   logic [31:0] wdata_c;

   assign opcode = inst_q[6:0];
   assign funct3 = inst_q[14:12];
   assign imm    = {{20{inst_q[31]}}, inst_q[31:25], inst_q[11:7]};
   assign ea     = rf_rs1_data + imm;

   assign illegal    = (opcode != 7'b0100011) || (funct3 > 3'b010);
   assign misaligned = ((funct3 == 3'b001) && ea[0]) ||
                       ((funct3 == 3'b010) && (ea[1:0] != 2'b00));

   always_comb begin
      wstrb_c = 4'b0000;
      wdata_c = 32'h0;
      case (funct3)
         3'b000: begin
            wstrb_c = 4'b0001 << ea[1:0];
            wdata_c = {4{rf_rs2_data[7:0]}};
         end
         3'b001: begin
            wstrb_c = 4'b0011 << ea[1:0];
            wdata_c = {2{rf_rs2_data[15:0]}};
         end
         3'b010: begin
            wstrb_c = 4'b1111;
            wdata_c = rf_rs2_data;
         end
         default: begin
            wstrb_c = 4'b0000;
            wdata_c = 32'h0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (inst_valid) state_nxt = S_READ;
         S_READ:  state_nxt = S_EXEC;
         S_EXEC:  state_nxt = (illegal || misaligned) ? S_FAULT : S_MEM;
         S_MEM:   if (mem_ready) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         S_FAULT: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      inst_ready  = (state == S_IDLE) && !rst;
      busy        = (state != S_IDLE);
      mem_valid   = (state == S_MEM);
      done        = (state == S_DONE);
      fault       = (state == S_FAULT);
      rf_rs1_addr = busy ? inst_q[19:15] : 5'd0;
      rf_rs2_addr = busy ? inst_q[24:20] : 5'd0;
   end

   // Request fields are only written in EXEC, so they stay frozen through MEM.
   always_ff @(posedge clk) begin
      if (rst) begin
         inst_q      <= 32'h0;
         mem_addr    <= 32'h0;
         mem_wdata   <= 32'h0;
         mem_wstrb   <= 4'b0000;
         fault_addr  <= 32'h0;
         fault_cause <= 2'b00;
      end else begin
         if (state == S_IDLE && inst_valid) inst_q <= instruction_word;
         if (state == S_EXEC) begin
            mem_addr  <= {ea[31:2], 2'b00};
            mem_wstrb <= wstrb_c;
            mem_wdata <= wdata_c;
            if (illegal || misaligned) begin
               fault_addr  <= ea;
               fault_cause <= illegal ? 2'b01 : 2'b10;
            end
         end
      end
   end

endmodule

// File: tb/tb_s_store_ctrl.sv
// Directed bench for s_store_ctrl: hand-computed store vectors, fault paths,
// backpressure and reset during an outstanding request.
module tb_s_store_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] instruction_word;
   logic [4:0]  rf_rs1_addr, rf_rs2_addr;
   logic [31:0] rf_rs1_data, rf_rs2_data;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        busy, done, fault;
   logic [1:0]  fault_cause;
   logic [31:0] fault_addr;

   int checks = 0;
   int errors = 0;

   logic [4:0]  exp_rs1, exp_rs2;
   logic [31:0] rs1_val, rs2_val;

   always #5 clk = ~clk;

   s_store_ctrl dut (
      .clk(clk), .rst(rst),
      .inst_valid(inst_valid), .inst_ready(inst_ready),
      .instruction_word(instruction_word),
      .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
      .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .busy(busy), .done(done), .fault(fault),
      .fault_cause(fault_cause), .fault_addr(fault_addr)
   );

   // Register-file model: one-cycle read latency; wrong address returns a poison value.
   always @(posedge clk) begin
      rf_rs1_data <= (rf_rs1_addr == exp_rs1) ? rs1_val : 32'hBAD0BAD0;
      rf_rs2_data <= (rf_rs2_addr == exp_rs2) ? rs2_val : 32'hBAD0BAD0;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents the instruction in cycle T; returns #1 into cycle T+1.
   task automatic issue(input logic [31:0] w, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [31:0] v1, input logic [31:0] v2);
      exp_rs1 = r1;
      exp_rs2 = r2;
      rs1_val = v1;
      rs2_val = v2;
      @(negedge clk);
      inst_valid       = 1'b1;
      instruction_word = w;
      tick();
      inst_valid       = 1'b0;
      instruction_word = 32'h0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      inst_valid = 1'b0;
      instruction_word = 32'h0;
      mem_ready = 1'b0;
      exp_rs1 = 5'd0; exp_rs2 = 5'd0; rs1_val = 32'h0; rs2_val = 32'h0;
      tick(); tick();
      checks++;
      if ({mem_valid, done, fault, busy, inst_ready} !== 5'b00000) begin
         errors++;
         $display("FAIL reset_ctrl: got %b want 00000", {mem_valid, done, fault, busy, inst_ready});
      end
      checks++;
      if ({mem_addr, mem_wdata, mem_wstrb, fault_addr, fault_cause} !== 102'h0) begin
         errors++;
         $display("FAIL reset_data: addr %h wdata %h wstrb %b faddr %h cause %b",
                  mem_addr, mem_wdata, mem_wstrb, fault_addr, fault_cause);
      end
      checks++;
      if ({rf_rs1_addr, rf_rs2_addr} !== 10'h0) begin
         errors++;
         $display("FAIL reset_rf_addr: got %h %h want 0 0", rf_rs1_addr, rf_rs2_addr);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (inst_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready: got %b want 1", inst_ready);
      end
   endtask

   task automatic test_sw_aligned();
      mem_ready = 1'b1;
      issue(32'b0000111_00000_01101_010_11101_0100011, 5'd13, 5'd0, 32'h10000003, 32'hCAFEF00D);
      checks++;
      if ({busy, inst_ready, rf_rs1_addr, rf_rs2_addr} !== {1'b1, 1'b0, 5'd13, 5'd0}) begin
         errors++;
         $display("FAIL sw_read: busy %b ready %b rs1 %0d rs2 %0d want 1 0 13 0",
                  busy, inst_ready, rf_rs1_addr, rf_rs2_addr);
      end
      tick();
      checks++;
      if (mem_valid !== 1'b0) begin
         errors++;
         $display("FAIL sw_exec_valid: got %b want 0", mem_valid);
      end
      tick();
      checks++;
      if ({mem_valid, mem_addr, mem_wstrb, mem_wdata} !== {1'b1, 32'h10000100, 4'b1111, 32'hCAFEF00D}) begin
         errors++;
         $display("FAIL sw_mem: valid %b addr %h wstrb %b wdata %h want 1 10000100 1111 cafef00d",
                  mem_valid, mem_addr, mem_wstrb, mem_wdata);
      end
      tick();
      checks++;
      if ({done, fault, mem_valid, inst_ready} !== 4'b1000) begin
         errors++;
         $display("FAIL sw_done_t4: done/fault/valid/ready %b want 1000", {done, fault, mem_valid, inst_ready});
      end
      tick();
      checks++;
      if ({done, inst_ready, busy} !== 3'b010) begin
         errors++;
         $display("FAIL sw_ready_t5: done/ready/busy %b want 010", {done, inst_ready, busy});
      end
   endtask

   task automatic test_sw_misaligned();
      mem_ready = 1'b1;
      issue(32'b0100101_10101_01100_010_01111_0100011, 5'd12, 5'd21, 32'h00000002, 32'h11111111);
      tick();
      tick();
      checks++;
      if ({fault, done, mem_valid, fault_cause, fault_addr} !== {3'b100, 2'b10, 32'h000004B1}) begin
         errors++;
         $display("FAIL sw_misaligned: fault %b done %b valid %b cause %b faddr %h want 1 0 0 10 000004b1",
                  fault, done, mem_valid, fault_cause, fault_addr);
      end
      tick();
      checks++;
      if ({fault, mem_valid, inst_ready, fault_cause} !== {3'b001, 2'b10}) begin
         errors++;
         $display("FAIL sw_misaligned_t4: fault %b valid %b ready %b cause %b want 0 0 1 10",
                  fault, mem_valid, inst_ready, fault_cause);
      end
   endtask

   task automatic test_sb_neg_imm();
      mem_ready = 1'b1;
      issue(32'b1000100_01011_00111_000_00001_0100011, 5'd7, 5'd11, 32'h00001000, 32'hDEADBEEF);
      tick();
      tick();
      checks++;
      if ({mem_valid, mem_addr, mem_wstrb, mem_wdata} !== {1'b1, 32'h00000880, 4'b0010, 32'hEFEFEFEF}) begin
         errors++;
         $display("FAIL sb_neg_imm: valid %b addr %h wstrb %b wdata %h want 1 00000880 0010 efefefef",
                  mem_valid, mem_addr, mem_wstrb, mem_wdata);
      end
      tick();
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL sb_done: got %b want 1", done);
      end
      tick();
   endtask

   task automatic test_sh_upper();
      mem_ready = 1'b1;
      issue({7'b0000111, 5'd6, 5'd5, 3'b001, 5'b11101, 7'b0100011}, 5'd5, 5'd6, 32'h00000001, 32'h1234ABCD);
      tick();
      tick();
      checks++;
      if ({mem_valid, mem_addr, mem_wstrb, mem_wdata} !== {1'b1, 32'h000000FC, 4'b1100, 32'hABCDABCD}) begin
         errors++;
         $display("FAIL sh_upper: valid %b addr %h wstrb %b wdata %h want 1 000000fc 1100 abcdabcd",
                  mem_valid, mem_addr, mem_wstrb, mem_wdata);
      end
      tick();
      tick();
   endtask

   task automatic test_illegal();
      mem_ready = 1'b1;
      issue(32'b0000111_00000_01101_010_11101_0110011, 5'd13, 5'd0, 32'h10000003, 32'h0);
      tick();
      tick();
      checks++;
      if ({fault, mem_valid, fault_cause, fault_addr} !== {2'b10, 2'b01, 32'h10000100}) begin
         errors++;
         $display("FAIL illegal_opcode: fault %b valid %b cause %b faddr %h want 1 0 01 10000100",
                  fault, mem_valid, fault_cause, fault_addr);
      end
      tick();
      // funct3 011 with a misaligned ea: legality outranks alignment
      issue(32'b0100101_10101_01100_011_01111_0100011, 5'd12, 5'd21, 32'h00000002, 32'h0);
      tick();
      tick();
      checks++;
      if ({fault, mem_valid, fault_cause, fault_addr} !== {2'b10, 2'b01, 32'h000004B1}) begin
         errors++;
         $display("FAIL illegal_funct3: fault %b valid %b cause %b faddr %h want 1 0 01 000004b1",
                  fault, mem_valid, fault_cause, fault_addr);
      end
      tick();
   endtask

   task automatic test_backpressure();
      mem_ready = 1'b0;
      issue(32'b0000111_00000_01101_010_11101_0100011, 5'd13, 5'd0, 32'h10000003, 32'h55AA33CC);
      tick();
      tick();
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({mem_valid, done, mem_addr, mem_wstrb, mem_wdata} !==
             {2'b10, 32'h10000100, 4'b1111, 32'h55AA33CC}) begin
            errors++;
            $display("FAIL backpressure_hold[%0d]: valid %b done %b addr %h wstrb %b wdata %h",
                     i, mem_valid, done, mem_addr, mem_wstrb, mem_wdata);
         end
         if (i < 2) tick();
      end
      @(negedge clk);
      mem_ready = 1'b1;
      tick();
      checks++;
      if ({done, mem_valid} !== 2'b10) begin
         errors++;
         $display("FAIL backpressure_done: done %b valid %b want 1 0", done, mem_valid);
      end
      tick();
   endtask

   task automatic test_reset_in_mem();
      mem_ready = 1'b0;
      issue(32'b0000111_00000_01101_010_11101_0100011, 5'd13, 5'd0, 32'h10000003, 32'h0F0F0F0F);
      tick();
      tick();
      checks++;
      if (mem_valid !== 1'b1) begin
         errors++;
         $display("FAIL rst_mem_setup: valid %b want 1", mem_valid);
      end
      rst = 1'b1;
      mem_ready = 1'b1;
      tick();
      checks++;
      if ({mem_valid, done, fault, busy, inst_ready} !== 5'b00000) begin
         errors++;
         $display("FAIL rst_in_mem: valid/done/fault/busy/ready %b want 00000",
                  {mem_valid, done, fault, busy, inst_ready});
      end
      rst = 1'b0;
      tick();
      checks++;
      if ({inst_ready, done, fault, mem_valid} !== 4'b1000) begin
         errors++;
         $display("FAIL rst_in_mem_after: ready/done/fault/valid %b want 1000",
                  {inst_ready, done, fault, mem_valid});
      end
   endtask

   initial begin
      test_reset();
      test_sw_aligned();
      test_sw_misaligned();
      test_sb_neg_imm();
      test_sh_upper();
      test_illegal();
      test_backpressure();
      test_reset_in_mem();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
